// File: rtl/wb_xbar_decoder_if.sv
// Bus bundle for the Wishbone 1-to-N decoder: host-side pipelined port plus shared/per-slave peripheral side.
interface wb_xbar_decoder_if #(
    parameter int unsigned N_SLAVES = 3,
    parameter int unsigned ADDR_W   = 18
);
    logic                   wb_cyc;
    logic                   wb_stb;
    logic                   wb_we;
    logic [ADDR_W-1:0]      wb_adr;
    logic [3:0]             wb_sel;
    logic [31:0]            wb_wdat;
    logic                   wb_ack;
    logic                   wb_err;
    logic                   wb_stall;
    logic [31:0]            wb_rdat;

    logic [N_SLAVES-1:0]    m_cyc;
    logic [N_SLAVES-1:0]    m_stb;
    logic                   m_we;
    logic [ADDR_W-1:0]      m_adr;
    logic [3:0]             m_sel;
    logic [31:0]            m_wdat;
    logic [N_SLAVES*32-1:0] m_rdat;
    logic [N_SLAVES-1:0]    m_ack;
    logic [N_SLAVES-1:0]    m_err;
    logic [N_SLAVES-1:0]    m_stall;

    logic                   tmo;
    logic [ADDR_W-1:0]      err_adr;

    // Decoder view: it is the slave of the host bridge.
    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_wdat,
        output wb_ack, wb_err, wb_stall, wb_rdat,
        output m_cyc, m_stb, m_we, m_adr, m_sel, m_wdat,
        input  m_rdat, m_ack, m_err, m_stall,
        output tmo, err_adr
    );

    // Host bridge and peripheral models view.
    modport master (
        output wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_wdat,
        input  wb_ack, wb_err, wb_stall, wb_rdat,
        input  m_cyc, m_stb, m_we, m_adr, m_sel, m_wdat,
        output m_rdat, m_ack, m_err, m_stall,
        input  tmo, err_adr
    );
endinterface

// File: rtl/wb_xbar_decoder.sv
// Wishbone B4-pipelined 1-to-N address decoder: BASE/MASK windows, single outstanding
// transaction, error on unmapped addresses and per-transaction timeout.
module wb_xbar_decoder #(
    parameter int unsigned                 N_SLAVES = 3,
    parameter int unsigned                 ADDR_W   = 18,
    parameter logic [N_SLAVES*ADDR_W-1:0]  SLV_BASE = {18'h10000, 18'h00000, 18'h08000},
    parameter logic [N_SLAVES*ADDR_W-1:0]  SLV_MASK = {18'h38000, 18'h30000, 18'h38000},
    parameter int unsigned                 TIMEOUT  = 255
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    wb_xbar_decoder_if.slave  bus
);
    localparam int unsigned SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ      = 3'd1,
        WAIT     = 3'd2,
        RESP_ACK = 3'd3,
        RESP_ERR = 3'd4
    } state_t;

    state_t              state;
    logic [SEL_W-1:0]    sel_q;
    logic [ADDR_W-1:0]   adr_q;
    logic [CNT_W-1:0]    cnt;

    logic                hit_c;
    logic [SEL_W-1:0]    hit_idx_c;
    logic [N_SLAVES-1:0] hit_oh_c;
    logic [ADDR_W-1:0]   hit_mask_c;

    logic                sel_ack_c;
    logic                sel_err_c;
    logic                sel_stall_c;
    logic [31:0]         sel_dat_c;
    logic                granted_c;
    logic                expire_c;

    // Window decode of the incoming address; the lowest matching index wins.
    always_comb begin
        hit_c      = 1'b0;
        hit_idx_c  = '0;
        hit_oh_c   = '0;
        hit_mask_c = '0;
        for (int k = 0; k < int'(N_SLAVES); k++) begin
            if (!hit_c && ((bus.wb_adr & SLV_MASK[k*ADDR_W +: ADDR_W]) == SLV_BASE[k*ADDR_W +: ADDR_W])) begin
                hit_c       = 1'b1;
                hit_idx_c   = SEL_W'(k);
                hit_oh_c[k] = 1'b1;
                hit_mask_c  = SLV_MASK[k*ADDR_W +: ADDR_W];
            end
        end
    end

    // Response mux from the slave owning the current transaction.
    always_comb begin
        sel_ack_c   = 1'b0;
        sel_err_c   = 1'b0;
        sel_stall_c = 1'b0;
        sel_dat_c   = '0;
        for (int k = 0; k < int'(N_SLAVES); k++) begin
            if (sel_q == SEL_W'(k)) begin
                sel_ack_c   = bus.m_ack[k];
                sel_err_c   = bus.m_err[k];
                sel_stall_c = bus.m_stall[k];
                sel_dat_c   = bus.m_rdat[k*32 +: 32];
            end
        end
    end

    // A response counts once the strobe has been accepted (WAIT, or REQ without stall).
    assign granted_c = (state == WAIT) || !sel_stall_c;
    assign expire_c  = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state        <= IDLE;
            sel_q        <= '0;
            adr_q        <= '0;
            cnt          <= '0;
            bus.wb_ack   <= 1'b0;
            bus.wb_err   <= 1'b0;
            bus.wb_stall <= 1'b0;
            bus.wb_rdat  <= '0;
            bus.m_cyc    <= '0;
            bus.m_stb    <= '0;
            bus.m_we     <= 1'b0;
            bus.m_adr    <= '0;
            bus.m_sel    <= '0;
            bus.m_wdat   <= '0;
            bus.tmo      <= 1'b0;
            bus.err_adr  <= '0;
        end else begin
            bus.wb_ack  <= 1'b0;
            bus.wb_err  <= 1'b0;
            bus.tmo     <= 1'b0;
            bus.wb_rdat <= '0;
            unique case (state)
                IDLE: begin
                    if (bus.wb_cyc && bus.wb_stb) begin
                        adr_q        <= bus.wb_adr;
                        bus.m_we     <= bus.wb_we;
                        bus.m_sel    <= bus.wb_sel;
                        bus.m_wdat   <= bus.wb_wdat;
                        bus.wb_stall <= 1'b1;
                        if (hit_c) begin
                            state     <= REQ;
                            sel_q     <= hit_idx_c;
                            cnt       <= '0;
                            bus.m_cyc <= hit_oh_c;
                            bus.m_stb <= hit_oh_c;
                            bus.m_adr <= bus.wb_adr & ~hit_mask_c;
                        end else begin
                            state       <= RESP_ERR;
                            bus.wb_err  <= 1'b1;
                            bus.err_adr <= bus.wb_adr;
                        end
                    end
                end
                REQ, WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    // Host abort beats any response or timeout arriving in the same cycle.
                    if (!bus.wb_cyc) begin
                        state        <= IDLE;
                        bus.m_cyc    <= '0;
                        bus.m_stb    <= '0;
                        bus.wb_stall <= 1'b0;
                    end else if (granted_c && sel_ack_c) begin
                        state       <= RESP_ACK;
                        bus.m_cyc   <= '0;
                        bus.m_stb   <= '0;
                        bus.wb_ack  <= 1'b1;
                        bus.wb_rdat <= sel_dat_c;
                    end else if (granted_c && sel_err_c) begin
                        state       <= RESP_ERR;
                        bus.m_cyc   <= '0;
                        bus.m_stb   <= '0;
                        bus.wb_err  <= 1'b1;
                        bus.err_adr <= adr_q;
                    end else if (expire_c) begin
                        state       <= RESP_ERR;
                        bus.m_cyc   <= '0;
                        bus.m_stb   <= '0;
                        bus.wb_err  <= 1'b1;
                        bus.tmo     <= 1'b1;
                        bus.err_adr <= adr_q;
                    end else if ((state == REQ) && !sel_stall_c) begin
                        state     <= WAIT;
                        bus.m_stb <= '0;
                    end
                end
                RESP_ACK, RESP_ERR: begin
                    state        <= IDLE;
                    bus.wb_stall <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    bus.m_cyc    <= '0;
                    bus.m_stb    <= '0;
                    bus.wb_stall <= 1'b0;
                end
            endcase
        end
    end
endmodule
